// File: rtl/fxp_mul_seq.sv
// Sequential signed fixed-point multiplier (Q(WIDTH-FBITS).FBITS).
// Magnitudes are multiplied with a shift-add loop, one multiplier bit per
// cycle. The sign is reapplied after rounding, and the result is then
// saturated or wrapped. Valid/ready handshakes are used on both sides.
module fxp_mul_seq #(
    parameter int WIDTH = 25,
    parameter int FBITS = 20,
    parameter bit SAT   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_a,
    input  logic signed [WIDTH-1:0] in_b,
    input  logic [1:0]              in_rmode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_ovf
);

    localparam int ACC_W = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, RND, OUT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               sign;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [1:0]         rmode;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_q;
    logic               accept;
    logic               last_bit;

    // Drop the fraction bits of the unsigned product and apply the rounding
    // increment. The rounding is done on the magnitude, so mode 1 rounds
    // halves away from zero.
    function automatic logic [ACC_W-1:0] round_mag(input logic [ACC_W-1:0] a,
                                                   input logic [1:0]       rm);
        logic [ACC_W-1:0] q;
        logic [FBITS-1:0] r;
        logic [FBITS-1:0] half;
        logic             inc;
        q             = a >> FBITS;
        r             = a[FBITS-1:0];
        half          = '0;
        half[FBITS-1] = 1'b1;
        case (rm)
            2'd1:    inc = (r >= half);
            2'd2:    inc = (r > half) || ((r == half) && q[0]);
            default: inc = 1'b0;
        endcase
        return q + ACC_W'(inc);
    endfunction

    // Reapply the sign and flag overflow. The negative range holds one more
    // magnitude (2^(W-1)) than the positive range. Returns {ovf, data}.
    function automatic logic [WIDTH:0] sign_sat(input logic [ACC_W-1:0] m,
                                                input logic             s);
        logic [ACC_W-1:0] lim;
        logic [ACC_W-1:0] v;
        logic [WIDTH-1:0] d;
        logic             ovf;
        lim = ACC_W'(1) << (WIDTH - 1);
        ovf = s ? (m > lim) : (m >= lim);
        v   = s ? (~m + ACC_W'(1)) : m;
        d   = v[WIDTH-1:0];
        if (ovf && SAT) begin
            d = s ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return {ovf, d};
    endfunction

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = MUL;
            MUL:     if (last_bit)  state_nxt = RND;
            RND:                    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state. ovf is masked outside OUT.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == OUT);
        out_ovf   = ovf_q && (state == OUT);
    end

    // Operand capture and the shift-add loop: multiplier bits LSB first.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign  <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
            mag_a <= in_a[WIDTH-1] ? $unsigned(-in_a) : $unsigned(in_a);
            mag_b <= in_b[WIDTH-1] ? $unsigned(-in_b) : $unsigned(in_b);
            rmode <= in_rmode;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == MUL) begin
            if (mag_a[cnt]) begin
                acc <= acc + ({{WIDTH{1'b0}}, mag_b} << cnt);
            end
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Round, sign and saturate into the result register; held through OUT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            ovf_q    <= 1'b0;
        end else if (state == RND) begin
            {ovf_q, out_data} <= sign_sat(round_mag(acc, rmode), sign);
        end
    end

endmodule

// File: tb/tb_fxp_mul_seq.sv
// Testbench for fxp_mul_seq. Two instances (saturating and wrapping) share
// the same stimulus. Expected results come from an integer-arithmetic model
// and are queued at acceptance. A monitor pops and compares them on every
// output handshake.
module tb_fxp_mul_seq;

    localparam int W = 25;
    localparam int F = 20;

    typedef struct {
        logic [W-1:0] d_sat;
        logic [W-1:0] d_wrap;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [1:0]   in_rmode = 2'd0;
    logic         out_ready = 1'b1;
    logic         in_ready_s, in_ready_w;
    logic         out_valid_s, out_valid_w;
    logic         ovf_s, ovf_w;
    logic [W-1:0] data_s, data_w;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random
    exp_t sb_q[$];

    fxp_mul_seq #(.WIDTH(W), .FBITS(F), .SAT(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_rmode(in_rmode), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(data_s), .out_ovf(ovf_s)
    );

    fxp_mul_seq #(.WIDTH(W), .FBITS(F), .SAT(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_a(in_a), .in_b(in_b), .in_rmode(in_rmode), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(data_w), .out_ovf(ovf_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready, driven after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: exact signed product, then rounding by division/remainder.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] rm);
        exp_t   e;
        longint sa, sb, p, mag, scale, q, r, half, m, v, maxv, minv;
        bit     neg, inc;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        p     = sa * sb;
        neg   = (p < 0);
        mag   = neg ? -p : p;
        scale = longint'(1) << F;
        q     = mag / scale;
        r     = mag % scale;
        half  = scale / 2;
        if (rm == 2'd1)      inc = (r >= half);
        else if (rm == 2'd2) inc = (r > half) || ((r == half) && ((q % 2) == 1));
        else                 inc = 1'b0;
        m     = q + longint'(inc);
        v     = neg ? -m : m;
        maxv  = (longint'(1) << (W - 1)) - 1;
        minv  = -(longint'(1) << (W - 1));
        e.ovf    = (v > maxv) || (v < minv);
        e.d_wrap = v[W-1:0];
        e.d_sat  = (v > maxv) ? maxv[W-1:0] : ((v < minv) ? minv[W-1:0] : v[W-1:0]);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        logic [W-1:0] v;
        v = W'($urandom);
        if ($urandom_range(0, 3) != 0) v = {{2{v[22]}}, v[22:0]};
        return v;
    endfunction

    // Present operands, wait for acceptance, queue the expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] rm, input bit push);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_rmode = rm;
        while (!in_ready_s && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready_s) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) sb_q.push_back(model(a, b, rm));
            #1;
            accept_cyc = cyc;
            in_valid   = 1'b0;
            in_a       = W'($urandom);
            in_b       = W'($urandom);
            in_rmode   = 2'($urandom);
        end
    endtask

    task automatic drain(input int limit);
        int guard;
        guard = 0;
        while ((sb_q.size() != 0 || out_valid_s) && guard < limit) begin
            @(negedge clk);
            guard++;
        end
        check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: latency on each rising out_valid, scoreboard on each handshake.
    initial begin
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid_s && !prev_v) check("latency", 64'(cyc - accept_cyc), 64'(W + 1));
                if (out_valid_s && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_output: got 0x%0h, expected no output", data_s);
                    end else begin
                        e = sb_q.pop_front();
                        check("data_sat", 64'(data_s), 64'(e.d_sat));
                        check("ovf_sat", 64'(ovf_s), 64'(e.ovf));
                        check("data_wrap", 64'(data_w), 64'(e.d_wrap));
                        check("ovf_wrap", 64'(ovf_w), 64'(e.ovf));
                        check("valid_pair", 64'(out_valid_w), 64'd1);
                    end
                end
                prev_v = out_valid_s;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] hold_d;
        logic         hold_o;
        int           guard;
        int           vcount;

        // Reset state
        rdy_mode = 0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid_s), 64'd0);
        check("rst_out_data", 64'(data_s), 64'd0);
        check("rst_out_ovf", 64'(ovf_s), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready_s), 64'd1);

        // Basic, rounding and overflow cases
        issue(25'h0180000, 25'h0200000, 2'd0, 1'b1);
        issue(25'h1E80000, 25'h0200000, 2'd0, 1'b1);
        for (int md = 0; md < 4; md++) begin
            issue(25'h0000001, 25'h0080000, 2'(md), 1'b1);
            issue(25'h0000003, 25'h0080000, 2'(md), 1'b1);
            issue(25'h1FFFFFF, 25'h0080000, 2'(md), 1'b1);
            issue(25'h1FFFFFD, 25'h0080000, 2'(md), 1'b1);
        end
        issue(25'h0800000, 25'h0400000, 2'd0, 1'b1);
        issue(25'h1000000, 25'h0100000, 2'd0, 1'b1);
        issue(25'h1000000, 25'h1F00000, 2'd0, 1'b1);
        issue(25'h0000000, 25'h1F00000, 2'd1, 1'b1);
        drain(100);

        // Backpressure: hold the result while ready is low
        rdy_mode = 1;
        issue(25'h0800000, 25'h0400000, 2'd1, 1'b1);
        guard = 0;
        while (!out_valid_s && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("bp_valid_seen", 64'(out_valid_s), 64'd1);
        hold_d   = data_s;
        hold_o   = ovf_s;
        in_valid = 1'b1;
        in_a     = 25'h0180000;
        in_b     = 25'h0200000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_held", 64'(out_valid_s), 64'd1);
            check("bp_data_stable", 64'(data_s), 64'(hold_d));
            check("bp_ovf_stable", 64'(ovf_s), 64'(hold_o));
            check("bp_in_ready_low", 64'(in_ready_s), 64'd0);
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        check("bp_in_ready_after", 64'(in_ready_s), 64'd1);
        check("bp_valid_after", 64'(out_valid_s), 64'd0);
        check("bp_ovf_after", 64'(ovf_s), 64'd0);
        drain(50);

        // Reset in the middle of MUL
        issue(25'h0180000, 25'h0200000, 2'd0, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", 64'(in_ready_s), 64'd1);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid_s) vcount++;
        end
        check("midrst_no_output", 64'(vcount), 64'd0);
        issue(25'h0180000, 25'h0200000, 2'd0, 1'b1);
        drain(100);

        // Random back-to-back with throttling
        rdy_mode = 2;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(rnd_opnd(), rnd_opnd(), 2'($urandom_range(0, 3)), 1'b1);
        end
        drain(500);
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
